store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_if.sv | 39 +++
 rtl/store_buffer.sv | 116 +++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - core-side and memory-side signal bundle for store_buffer
//
// Ports (grouped as interface signals):
//   core store in : MemWrite, DataAdr[31:0], WriteData[31:0], stall
//   memory out    : mem_valid, mem_addr[31:0], mem_wdata[31:0], mem_ready
//   status        : count[$clog2(DEPTH):0], empty, err_misalign
//   forwarding    : ReadAdr[31:0], fwd_hit, fwd_data[31:0]
// Modports: master = core/memory side, slave = store_buffer.

interface store_buffer_if #(
    parameter int DEPTH = 4
);
    logic                      MemWrite;
    logic [31:0]               DataAdr;
    logic [31:0]               WriteData;
    logic                      stall;
    logic                      mem_valid;
    logic [31:0]               mem_addr;
    logic [31:0]               mem_wdata;
    logic                      mem_ready;
    logic [$clog2(DEPTH):0]    count;
    logic                      empty;
    logic                      err_misalign;
    logic [31:0]               ReadAdr;
    logic                      fwd_hit;
    logic [31:0]               fwd_data;

    modport master (
        output MemWrite, DataAdr, WriteData, mem_ready, ReadAdr,
        input  stall, mem_valid, mem_addr, mem_wdata, count, empty,
               err_misalign, fwd_hit, fwd_data
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData, mem_ready, ReadAdr,
        output stall, mem_valid, mem_addr, mem_wdata, count, empty,
               err_misalign, fwd_hit, fwd_data
    );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - circular FIFO store buffer between core and data memory
//
// Ports:
//   clk   : single clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : store_buffer_if.slave (core store in, memory drain out, status,
//           load-forwarding lookup)
// Parameter DEPTH: power of two, 2..16.
// Optional feature macro STORE_FWD_EN: builds the store-to-load forwarding
// lookup; when undefined fwd_hit/fwd_data are tied to 0.

module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic          full;
    logic          aligned;
    logic          enq;
    logic          deq;

    assign full    = (count_q == CW'(DEPTH));
    assign aligned = (bus.DataAdr[1:0] == 2'b00);
    // Full is judged on the registered count, so a same-cycle dequeue never
    // makes room for the store that is currently stalled.
    assign enq     = bus.MemWrite & ~full & aligned;
    assign deq     = (count_q != '0) & bus.mem_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        // Misaligned stores only flag an error when they would otherwise
        // have been accepted; a full buffer just stalls them.
        err_d   = bus.MemWrite & ~full & ~aligned;
        if (enq) tail_d = tail_q + 1'b1;
        if (deq) head_d = head_q + 1'b1;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Entry storage is not reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail_q] <= bus.DataAdr;
            data_mem[tail_q] <= bus.WriteData;
        end
    end

    assign bus.stall        = bus.MemWrite & full;
    assign bus.mem_valid    = (count_q != '0);
    assign bus.empty        = (count_q == '0);
    assign bus.count        = count_q;
    assign bus.mem_addr     = addr_mem[head_q];
    assign bus.mem_wdata    = data_mem[head_q];
    assign bus.err_misalign = err_q;

`ifdef STORE_FWD_EN
    logic          hit_c;
    logic [31:0]   fdata_c;
    logic [AW-1:0] idx;

    // Scan oldest to newest so the newest matching entry wins. Only
    // registered entries are visible, so a store enqueued this cycle is
    // excluded from the lookup.
    always_comb begin
        hit_c   = 1'b0;
        fdata_c = '0;
        idx     = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if ((CW'(i) < count_q) && (addr_mem[idx][31:2] == bus.ReadAdr[31:2])) begin
                hit_c   = 1'b1;
                fdata_c = data_mem[idx];
            end
        end
    end

    assign bus.fwd_hit  = hit_c;
    assign bus.fwd_data = fdata_c;
`else
    assign bus.fwd_hit  = 1'b0;
    assign bus.fwd_data = '0;
`endif

endmodule
